// File: rtl/loader_sdram_bridge_pkg.sv
// Types and constants shared by the iNES loader and its SDRAM write bridge.
package loader_pkg;

  localparam int AW_DEFAULT = 22;
  localparam logic [AW_DEFAULT-1:0] CHR_BASE = 22'h200000;

  typedef struct packed {
    logic [AW_DEFAULT-1:0] addr;
    logic [7:0]            data;
  } loader_wr_t;

endpackage

// File: rtl/loader_sdram_bridge_if.sv
// Loader write stream in, SDRAM port-A write request and download status out.
interface loader_sdram_bridge_if
  import loader_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clear;
  logic          in_write;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic          loader_done;
  logic          slot;
  logic          out_we;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic [LW-1:0] level;
  logic          overflow;
  logic          flushed;

  modport master (
    output clear, in_write, in_addr, in_data, loader_done, slot,
    input  out_we, out_addr, out_data, level, overflow, flushed
  );

  modport slave (
    input  clear, in_write, in_addr, in_data, loader_done, slot,
    output out_we, out_addr, out_data, level, overflow, flushed
  );

endinterface

// File: rtl/loader_sdram_bridge_sync_fifo.sv
// Single-clock FIFO with registered occupancy; head is readable combinationally.
// A push while full is only taken when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 30,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the occupancy count, not from pointer compare.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/loader_sdram_bridge.sv
// Queues loader byte writes and replays one per SDRAM CPU slot; out_we holds a whole slot window.
// A push while full is dropped (sticky overflow) unless a slot pop frees an entry that cycle.
module loader_sdram_bridge
  import loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  loader_sdram_bridge_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int W  = AW + 8;

  logic [W-1:0]  head;
  logic          full;
  logic          empty;
  logic [LW-1:0] count;
  logic          pop;

  // Only the head present before this edge may pop; a same-cycle push waits for the next slot.
  assign pop = bus.slot && !empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .push  (bus.in_write),
    .pop   (pop),
    .din   ({bus.in_addr, bus.in_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.level = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_we   <= 1'b0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      bus.overflow <= 1'b0;
      bus.flushed  <= 1'b0;
    end else if (bus.clear) begin
      bus.out_we   <= 1'b0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      bus.overflow <= 1'b0;
      bus.flushed  <= 1'b0;
    end else begin
      if (bus.slot) begin
        bus.out_we <= pop;
        if (pop) begin
          bus.out_addr <= head[W-1:8];
          bus.out_data <= head[7:0];
        end
      end
      if (bus.in_write && full && !pop) bus.overflow <= 1'b1;
      bus.flushed <= bus.loader_done && (count == '0) && !bus.out_we;
    end
  end

endmodule
